// File: rtl/sample_sched_if.sv
// Sampler-side and result-stream signals of the batch scheduler, bundled so the
// scheduler (master) and the sampler/host side (slave) see consistent directions.
interface sample_sched_if #(
  parameter int BIT_WID = 8,
  parameter int POSSI_S = 32,
  parameter int RES_W   = 80
) ();
  logic [BIT_WID*POSSI_S-1:0] accu_distr;
  logic                       samp_enable;
  logic                       samp_done;
  logic [RES_W-1:0]           samp_result;
  logic                       res_valid;
  logic                       res_ready;
  logic [RES_W-1:0]           res_data;
  logic                       res_last;

  modport master (
    output accu_distr, samp_enable, res_valid, res_data, res_last,
    input  samp_done, samp_result, res_ready
  );

  modport slave (
    input  accu_distr, samp_enable, res_valid, res_data, res_last,
    output samp_done, samp_result, res_ready
  );
endinterface

// File: rtl/sample_sched.sv
// Batch scheduler for the parallel sampler: holds the accumulated distribution
// table, validates it on start, then runs one enable/done batch at a time.
module sample_sched #(
  parameter int BIT_WID = 8,
  parameter int POSSI_S = 32,
  parameter int IDX_W   = 5,
  parameter int RES_W   = 80,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [BIT_WID-1:0] cfg_data,
  input  logic               start,
  input  logic [CNT_W-1:0]   batch_cnt,
  input  logic               abort,
  output logic               busy,
  output logic               job_done,
  output logic               cfg_err,
  sample_sched_if.master     sif
);

  typedef enum logic [1:0] {IDLE, CHECK, RUN, HOLD} state_t;

  state_t                           state;
  logic [POSSI_S-1:0][BIT_WID-1:0]  tbl;
  logic [IDX_W-1:0]                 idx;
  logic [IDX_W-1:0]                 prev_idx;
  logic [CNT_W-1:0]                 remaining;
  logic                             mono_ok;
  logic                             step_ok;
  logic                             samp_enable;
  logic                             res_valid;
  logic                             res_last;
  logic [RES_W-1:0]                 res_data;

  assign prev_idx = idx - IDX_W'(1);
  // Running monotonicity verdict including the compare made this cycle.
  assign step_ok  = mono_ok && (tbl[idx] >= tbl[prev_idx]);
  assign busy     = (state != IDLE);

  assign sif.accu_distr  = tbl;
  assign sif.samp_enable = samp_enable;
  assign sif.res_valid   = res_valid;
  assign sif.res_data    = res_data;
  assign sif.res_last    = res_last;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the table is a flop-based register file, not a RAM, so it can and must be cleared by reset.
      tbl         <= '0;
      state       <= IDLE;
      idx         <= '0;
      remaining   <= '0;
      mono_ok     <= 1'b0;
      job_done    <= 1'b0;
      cfg_err     <= 1'b0;
      samp_enable <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_last    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every branch below reads pre-edge values.
      job_done <= 1'b0;
      if (state != IDLE && abort) begin
        samp_enable <= 1'b0;
        res_valid   <= 1'b0;
        job_done    <= 1'b1;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // A write in the start cycle lands before the first CHECK compare.
            if (cfg_we) tbl[cfg_addr] <= cfg_data;
            if (start) begin
              remaining <= batch_cnt;
              cfg_err   <= 1'b0;
              idx       <= IDX_W'(1);
              mono_ok   <= 1'b1;
              state     <= CHECK;
            end
          end
          CHECK: begin
            mono_ok <= step_ok;
            idx     <= idx + IDX_W'(1);
            if (idx == IDX_W'(POSSI_S - 1)) begin
              if (step_ok && (tbl[POSSI_S-1] == '1)) begin
                if (remaining == '0) begin
                  job_done <= 1'b1;
                  state    <= IDLE;
                end else begin
                  samp_enable <= 1'b1;
                  state       <= RUN;
                end
              end else begin
                cfg_err  <= 1'b1;
                job_done <= 1'b1;
                state    <= IDLE;
              end
            end
          end
          RUN: begin
            if (sif.samp_done) begin
              res_data    <= sif.samp_result;
              res_valid   <= 1'b1;
              res_last    <= (remaining == CNT_W'(1));
              remaining   <= remaining - CNT_W'(1);
              samp_enable <= 1'b0;
              state       <= HOLD;
            end
          end
          HOLD: begin
            // res_valid is always high here; only the host handshake moves on.
            if (sif.res_ready) begin
              res_valid <= 1'b0;
              if (remaining == '0) begin
                job_done <= 1'b1;
                state    <= IDLE;
              end else begin
                samp_enable <= 1'b1;
                state       <= RUN;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_sched.sv
// Directed bench for sample_sched: table-driven job vectors plus hand-written
// backpressure, abort, interference and reset sequences.
module tb_sample_sched;

  logic         clk = 1'b0;
  logic         rstn;
  logic         cfg_we;
  logic [4:0]   cfg_addr;
  logic [7:0]   cfg_data;
  logic         start;
  logic [15:0]  batch_cnt;
  logic         abort;
  logic         busy;
  logic         job_done;
  logic         cfg_err;

  sample_sched_if #(.BIT_WID(8), .POSSI_S(32), .RES_W(80)) sif ();

  sample_sched dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .batch_cnt (batch_cnt),
    .abort     (abort),
    .busy      (busy),
    .job_done  (job_done),
    .cfg_err   (cfg_err),
    .sif       (sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Sampler model: done pulse after 4 cycles of enable, result tagged with a running index.
  int model_cnt = 0;
  int gen_n     = 0;
  initial begin
    sif.samp_done   = 1'b0;
    sif.samp_result = '0;
  end
  always @(negedge clk) begin
    sif.samp_done = 1'b0;
    if (sif.samp_enable) begin
      model_cnt++;
      if (model_cnt == 4) begin
        sif.samp_done   = 1'b1;
        sif.samp_result = {16'hBEEF, 32'hCAFE_0000, 32'(gen_n)};
        gen_n++;
        model_cnt = 0;
      end
    end else begin
      model_cnt = 0;
    end
  end

  function automatic logic [79:0] exp_result(input int n);
    return {16'hBEEF, 32'hCAFE_0000, 32'(n)};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [255:0] exp_tbl = '0;

  task automatic write_entry(input int a, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = 5'(a);
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
    exp_tbl[a*8 +: 8] = d;
  endtask

  task automatic write_ramp(input logic [7:0] e9, input logic [7:0] e10, input logic [7:0] e31);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] v;
      v = 8'(8 * i + 7);
      if (i == 9)  v = e9;
      if (i == 10) v = e10;
      if (i == 31) v = e31;
      write_entry(i, v);
    end
  endtask

  // Job observation results, cycle numbers relative to the start cycle.
  int           en_c, done_c, ndone;
  logic         err_at_done;
  logic [79:0]  res_q[$];
  logic         last_q[$];

  task automatic run_job(input logic [15:0] cnt);
    int k;
    en_c = 0; done_c = 0; ndone = 0; err_at_done = 1'b0;
    res_q.delete();
    last_q.delete();
    start     = 1'b1;
    batch_cnt = cnt;
    tick();
    start = 1'b0;
    k = 1;
    while (k < 3000 && (done_c == 0 || k < done_c + 3)) begin
      if (sif.samp_enable && en_c == 0) en_c = k;
      if (sif.res_valid && sif.res_ready) begin
        res_q.push_back(sif.res_data);
        last_q.push_back(sif.res_last);
      end
      if (job_done) begin
        ndone++;
        done_c      = k;
        err_at_done = cfg_err;
      end
      tick();
      k++;
    end
    check("job_timeout", 256'(done_c == 0), 256'(0));
  endtask

  typedef struct {
    logic [7:0]  e9;
    logic [7:0]  e10;
    logic [7:0]  e31;
    logic [15:0] cnt;
    logic        exp_err;
    int          exp_en;
    int          exp_done;
    int          exp_nres;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base;
    logic [79:0] held;
    int bad;
    int w;

    // {e9, e10, e31, batches, cfg_err, enable cycle, done cycle, results}
    vecs[0] = '{8'h4F, 8'h57, 8'hFF, 16'd3, 1'b0, 32, 47, 3};
    vecs[1] = '{8'h50, 8'h40, 8'hFF, 16'd3, 1'b1,  0, 32, 0};
    vecs[2] = '{8'h4F, 8'h57, 8'hFE, 16'd2, 1'b1,  0, 32, 0};
    vecs[3] = '{8'h4F, 8'h57, 8'hFF, 16'd0, 1'b0,  0, 32, 0};
    vecs[4] = '{8'h57, 8'h57, 8'hFF, 16'd1, 1'b0, 32, 37, 1};

    rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; batch_cnt = '0; abort = 1'b0; sif.res_ready = 1'b1;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    check("rst_busy", 256'(busy), 256'(0));
    check("rst_job_done", 256'(job_done), 256'(0));
    check("rst_cfg_err", 256'(cfg_err), 256'(0));
    check("rst_accu", 256'(sif.accu_distr), 256'(0));
    check("rst_outs", 256'({sif.samp_enable, sif.res_valid, sif.res_last, sif.res_data}), 256'(0));

    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort", 256'({busy, job_done}), 256'(0));

    foreach (vecs[v]) begin
      write_ramp(vecs[v].e9, vecs[v].e10, vecs[v].e31);
      check($sformatf("v%0d_readback", v), 256'(sif.accu_distr), exp_tbl);
      base = gen_n;
      run_job(vecs[v].cnt);
      check($sformatf("v%0d_cfg_err", v), 256'(err_at_done), 256'(vecs[v].exp_err));
      check($sformatf("v%0d_en_cycle", v), 256'(en_c), 256'(vecs[v].exp_en));
      check($sformatf("v%0d_done_cycle", v), 256'(done_c), 256'(vecs[v].exp_done));
      check($sformatf("v%0d_done_count", v), 256'(ndone), 256'(1));
      check($sformatf("v%0d_nres", v), 256'(res_q.size()), 256'(vecs[v].exp_nres));
      foreach (res_q[j]) begin
        check($sformatf("v%0d_res%0d_data", v, j), 256'(res_q[j]), 256'(exp_result(base + j)));
        check($sformatf("v%0d_res%0d_last", v, j), 256'(last_q[j]), 256'(j == vecs[v].exp_nres - 1));
      end
    end

    // Backpressure with a write attempt while busy.
    write_ramp(8'h4F, 8'h57, 8'hFF);
    base = gen_n;
    sif.res_ready = 1'b0;
    start = 1'b1; batch_cnt = 16'd2;
    tick();
    start = 1'b0;
    w = 0;
    while (!sif.res_valid && w < 100) begin tick(); w++; end
    check("bp_valid_seen", 256'(sif.res_valid), 256'(1));
    held = sif.res_data;
    check("bp_data", 256'(held), 256'(exp_result(base)));
    check("bp_last_first", 256'(sif.res_last), 256'(0));
    cfg_we = 1'b1; cfg_addr = 5'd5; cfg_data = 8'h00;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      cfg_we = 1'b0;
      if (sif.res_data !== held || !sif.res_valid || sif.samp_enable || sif.res_last) bad++;
    end
    check("bp_stable_cycles", 256'(bad), 256'(0));
    sif.res_ready = 1'b1;
    tick();
    check("bp_enable_after_hs", 256'({sif.samp_enable, sif.res_valid}), 256'(2'b10));
    w = 0;
    while (!job_done && w < 100) begin tick(); w++; end
    check("bp_job_done", 256'(job_done), 256'(1));
    check("busy_write_ignored", 256'(sif.accu_distr), exp_tbl);

    // Abort during RUN.
    start = 1'b1; batch_cnt = 16'd5;
    tick();
    start = 1'b0;
    w = 0;
    while (!sif.samp_enable && w < 100) begin tick(); w++; end
    check("ab_run_seen", 256'(sif.samp_enable), 256'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_outputs", 256'({sif.samp_enable, sif.res_valid, job_done, busy, cfg_err}), 256'(5'b00100));
    tick();
    check("ab_done_pulse_once", 256'(job_done), 256'(0));

    // Reset in the middle of HOLD.
    sif.res_ready = 1'b0;
    start = 1'b1; batch_cnt = 16'd2;
    tick();
    start = 1'b0;
    w = 0;
    while (!sif.res_valid && w < 100) begin tick(); w++; end
    check("rh_hold_seen", 256'(sif.res_valid), 256'(1));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rh_ctrl", 256'({busy, job_done, cfg_err, sif.samp_enable, sif.res_valid, sif.res_last}), 256'(0));
    check("rh_data", 256'(sif.res_data), 256'(0));
    check("rh_accu", 256'(sif.accu_distr), 256'(0));
    sif.res_ready = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
